// File: rtl/ofs_plat_prim_burstcount0_write_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ofs_plat_prim_burstcount0_write_arbiter_pkg
//
// Shared definitions for the burst-aware write arbiter:
//   arb_state_e     - arbiter state, exported on the top's dbg_state port
//   port_idx_width  - width of a port index, $clog2(n) with a floor of 1 so
//                     that a degenerate one-port build still has a real bit
// ----------------------------------------------------------------------------
package ofs_plat_prim_burstcount0_write_arbiter_pkg;

  // ARB_IDLE  : between packets, the next accepted flit is an SOP and the
  //             round-robin search picks the winner.
  // ARB_BURST : a multi-beat packet is in flight and the grant is pinned.
  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  function automatic int port_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ofs_plat_prim_burstcount0_write_arbiter_if.sv
// ----------------------------------------------------------------------------
// ofs_plat_prim_burstcount0_write_arbiter_if
//
// Bundle of the per-port write sources and the single shared write channel.
//
// Handshake: a flit moves on a rising clk edge exactly when valid and ready
// are both high on that channel. A source holding valid keeps its flit
// (data, burstcount) stable until it is accepted and never withdraws valid
// while waiting. Ready may be asserted without valid; it carries no meaning
// then. in_ready[i] is computed from out_ready and the current grant and
// therefore may depend on the valids of other ports through arbitration.
//
// Signals:
//   in_valid/in_ready        per-port flit handshake
//   in_burstcount            per-port burst length, origin 0 (0 = 1 beat)
//   in_data                  per-port payload
//   out_valid/out_ready      shared channel handshake
//   out_burstcount/out_data  granted port's burstcount and payload
//   out_sop/out_eop          first / last flit of the packet
//   out_port                 index of the granted port
//
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (sources + downstream sink)
// ----------------------------------------------------------------------------
interface ofs_plat_prim_burstcount0_write_arbiter_if
  import ofs_plat_prim_burstcount0_write_arbiter_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int BURST_CNT_WIDTH = 8,
  parameter int DATA_WIDTH      = 512
);

  localparam int PORT_W = port_idx_width(NUM_PORTS);

  logic [NUM_PORTS-1:0]                      in_valid;
  logic [NUM_PORTS-1:0]                      in_ready;
  logic [NUM_PORTS-1:0][BURST_CNT_WIDTH-1:0] in_burstcount;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]      in_data;

  logic                                      out_valid;
  logic                                      out_ready;
  logic [BURST_CNT_WIDTH-1:0]                out_burstcount;
  logic [DATA_WIDTH-1:0]                     out_data;
  logic                                      out_sop;
  logic                                      out_eop;
  logic [PORT_W-1:0]                         out_port;

  modport slave (
    input  in_valid,
    input  in_burstcount,
    input  in_data,
    output in_ready,
    output out_valid,
    input  out_ready,
    output out_burstcount,
    output out_data,
    output out_sop,
    output out_eop,
    output out_port
  );

  modport master (
    output in_valid,
    output in_burstcount,
    output in_data,
    input  in_ready,
    input  out_valid,
    output out_ready,
    input  out_burstcount,
    input  out_data,
    input  out_sop,
    input  out_eop,
    input  out_port
  );

endinterface

// File: rtl/ofs_plat_prim_burstcount0_write_arbiter_rr_select.sv
// ----------------------------------------------------------------------------
// ofs_plat_prim_rr_select
//
// Purely combinational round-robin search. Starting at last_grant+1 and
// wrapping modulo NUM_PORTS, returns the first requesting port.
//
// Ports:
//   req           in   NUM_PORTS  request vector
//   last_grant    in   PORT_W     most recently granted port
//   winner_valid  out  1          at least one request is set
//   winner_idx    out  PORT_W     selected port (0 when winner_valid is low)
// ----------------------------------------------------------------------------
module ofs_plat_prim_rr_select
  import ofs_plat_prim_burstcount0_write_arbiter_pkg::*;
#(
  parameter int  NUM_PORTS = 2,
  localparam int PORT_W    = port_idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    last_grant,
  output logic                 winner_valid,
  output logic [PORT_W-1:0]    winner_idx
);

  always_comb begin
    logic [PORT_W-1:0] cand;
    winner_valid = 1'b0;
    winner_idx   = '0;
    cand         = '0;
    // Offset NUM_PORTS wraps back to last_grant itself, so a lone requester
    // that was just served can still win again.
    for (int off = 1; off <= NUM_PORTS; off++) begin
      cand = PORT_W'((int'(last_grant) + off) % NUM_PORTS);
      if (!winner_valid && req[cand]) begin
        winner_valid = 1'b1;
        winner_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/ofs_plat_prim_burstcount0_write_arbiter.sv
// ----------------------------------------------------------------------------
// ofs_plat_prim_burstcount0_write_arbiter
//
// Round-robin arbiter sharing one burst-structured write channel among
// NUM_PORTS sources. Arbitration happens only at packet boundaries: the port
// that wins an SOP flit keeps the grant until its EOP flit is accepted,
// bubbles included. Zero latency, no buffering: every out_* signal is
// combinational from the inputs and the registered lock state.
//
// Parameters:
//   NUM_PORTS        number of sources (2..16)
//   BURST_CNT_WIDTH  burst count width, origin 0 (0 = 1 beat)
//   DATA_WIDTH       payload width per flit
//
// Ports:
//   clk        in   single clock, posedge
//   reset_n    in   asynchronous active-low reset
//   bus        if   slave modport of the arbiter interface
//   dbg_state  out  arbiter state (ARB_IDLE / ARB_BURST)
// ----------------------------------------------------------------------------
module ofs_plat_prim_burstcount0_write_arbiter
  import ofs_plat_prim_burstcount0_write_arbiter_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int BURST_CNT_WIDTH = 8,
  parameter int DATA_WIDTH      = 512
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  ofs_plat_prim_burstcount0_write_arbiter_if.slave  bus,
  output arb_state_e                                dbg_state
);

  localparam int PORT_W = port_idx_width(NUM_PORTS);

  // Registered state; "locked" is state == ARB_BURST.
  arb_state_e                 state;
  logic [PORT_W-1:0]          lock_port;
  logic [PORT_W-1:0]          last_grant;
  logic [BURST_CNT_WIDTH-1:0] flits_rem;

  logic                       rr_valid;
  logic [PORT_W-1:0]          rr_idx;

  logic                       win_valid;
  logic                       win_exists;
  logic [PORT_W-1:0]          win_idx;
  logic [BURST_CNT_WIDTH-1:0] win_bc;
  logic                       accept;

  ofs_plat_prim_rr_select #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr_select (
    .req          (bus.in_valid),
    .last_grant   (last_grant),
    .winner_valid (rr_valid),
    .winner_idx   (rr_idx)
  );

  // Winner selection. While reset is asserted the winner is forced to port 0
  // with no valid so that every forwarding output reads its reset value.
  always_comb begin
    win_idx    = '0;
    win_valid  = 1'b0;
    win_exists = 1'b0;
    if (reset_n) begin
      if (state == ARB_BURST) begin
        win_idx    = lock_port;
        win_valid  = bus.in_valid[lock_port];
        // The locked port keeps its ready even through a bubble.
        win_exists = 1'b1;
      end else begin
        win_idx    = rr_idx;
        win_valid  = rr_valid;
        win_exists = rr_valid;
      end
    end
  end

  assign win_bc = bus.in_burstcount[win_idx];
  assign accept = win_valid && bus.out_ready;

  assign bus.out_valid      = win_valid;
  assign bus.out_burstcount = win_bc;
  assign bus.out_data       = bus.in_data[win_idx];
  assign bus.out_port       = win_idx;
  assign bus.out_sop        = (state == ARB_IDLE);
  // In a burst the remaining-beat counter decides EOP; at SOP it is the
  // packet's own burstcount (0 means a single-beat packet).
  assign bus.out_eop        = reset_n &&
                              ((state == ARB_BURST) ? (flits_rem == '0)
                                                    : (win_bc == '0));

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      bus.in_ready[i] = win_exists && bus.out_ready && (win_idx == PORT_W'(i));
    end
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARB_IDLE;
      lock_port  <= '0;
      // Pointing at the last port gives port 0 first priority after reset.
      last_grant <= PORT_W'(NUM_PORTS - 1);
      flits_rem  <= '0;
    end else if (accept) begin
      case (state)
        ARB_IDLE: begin
          last_grant <= win_idx;
          if (win_bc != '0) begin
            state     <= ARB_BURST;
            lock_port <= win_idx;
            flits_rem <= win_bc - BURST_CNT_WIDTH'(1);
          end
        end
        ARB_BURST: begin
          // Burstcount on non-SOP beats is ignored; only the counter counts.
          flits_rem <= flits_rem - BURST_CNT_WIDTH'(1);
          if (flits_rem == '0) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofs_plat_prim_burstcount0_write_arbiter.sv
module tb_ofs_plat_prim_burstcount0_write_arbiter;
  import ofs_plat_prim_burstcount0_write_arbiter_pkg::*;

  localparam int NP = 2;
  localparam int BW = 8;
  localparam int DW = 512;

  logic       clk;
  logic       reset_n;
  arb_state_e dbg_state;

  int n_checks;
  int n_fail;

  ofs_plat_prim_burstcount0_write_arbiter_if #(
    .NUM_PORTS(NP), .BURST_CNT_WIDTH(BW), .DATA_WIDTH(DW)
  ) bus ();

  ofs_plat_prim_burstcount0_write_arbiter #(
    .NUM_PORTS(NP), .BURST_CNT_WIDTH(BW), .DATA_WIDTH(DW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver helpers ----------------
  function automatic logic [DW-1:0] mk(input int p, input int b);
    return DW'((p << 16) | b);
  endfunction

  task automatic drive_port(input int p, input logic v, input int bc, input int b);
    bus.in_valid[p]      = v;
    bus.in_burstcount[p] = BW'(bc);
    bus.in_data[p]       = mk(p, b);
  endtask

  task automatic idle_all();
    for (int p = 0; p < NP; p++) drive_port(p, 1'b0, 0, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle_all();
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    bus.out_ready = 1'b1;
    drive_port(0, 1'b1, 0, 0);
    drive_port(1, 1'b1, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (bus.in_ready !== 2'b00) begin n_fail++; $display("FAIL reset_in_ready got %b exp 00", bus.in_ready); end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    n_checks++;
    if (bus.out_sop !== 1'b1) begin n_fail++; $display("FAIL reset_out_sop got %b exp 1", bus.out_sop); end
    n_checks++;
    if (bus.out_eop !== 1'b0) begin n_fail++; $display("FAIL reset_out_eop got %b exp 0", bus.out_eop); end
    n_checks++;
    if (bus.out_port !== 1'b0) begin n_fail++; $display("FAIL reset_out_port got %0d exp 0", bus.out_port); end
    n_checks++;
    if (dbg_state !== ARB_IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    idle_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Port 0 alone, burstcount 3: 4 beats; burstcount changes after SOP ignored.
  task automatic test_single_burst();
    apply_reset();
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      drive_port(0, 1'b1, (b == 0) ? 3 : 7, b);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_port !== 1'b0 || bus.in_ready !== 2'b01) begin
        n_fail++;
        $display("FAIL single_grant beat %0d got v=%b port=%0d rdy=%b exp v=1 port=0 rdy=01",
                 b, bus.out_valid, bus.out_port, bus.in_ready);
      end
      n_checks++;
      if (bus.out_sop !== (b == 0) || bus.out_eop !== (b == 3)) begin
        n_fail++;
        $display("FAIL single_sop_eop beat %0d got sop=%b eop=%b exp sop=%b eop=%b",
                 b, bus.out_sop, bus.out_eop, (b == 0), (b == 3));
      end
      n_checks++;
      if (bus.out_data !== mk(0, b) || bus.out_burstcount !== BW'((b == 0) ? 3 : 7)) begin
        n_fail++;
        $display("FAIL single_data beat %0d got data=%0h bc=%0d", b, bus.out_data[31:0], bus.out_burstcount);
      end
    end
    @(negedge clk);
    idle_all();
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || dbg_state !== ARB_IDLE || bus.out_sop !== 1'b1) begin
      n_fail++;
      $display("FAIL single_unlock got v=%b state=%0d sop=%b exp v=0 state=0 sop=1",
               bus.out_valid, dbg_state, bus.out_sop);
    end
  endtask

  // Both ports single-beat every cycle: 0,1,0,1.
  task automatic test_alternate();
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive_port(0, 1'b1, 0, c);
      drive_port(1, 1'b1, 0, c);
      #1;
      n_checks++;
      if (bus.out_port !== 1'((c % 2)) || bus.out_sop !== 1'b1 || bus.out_eop !== 1'b1 ||
          bus.in_ready !== ((c % 2 == 1) ? 2'b10 : 2'b01) || bus.out_data !== mk(c % 2, c)) begin
        n_fail++;
        $display("FAIL alternate cycle %0d got port=%0d sop=%b eop=%b rdy=%b exp port=%0d sop=1 eop=1",
                 c, bus.out_port, bus.out_sop, bus.out_eop, bus.in_ready, c % 2);
      end
    end
    @(negedge clk);
    idle_all();
  endtask

  // Port 0 burstcount 2 with port 1 waiting: 3 contiguous port-0 beats.
  task automatic test_lock_hold();
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive_port(0, 1'b1, 2, c);
      drive_port(1, 1'b1, 0, c);
      #1;
      n_checks++;
      if (bus.out_port !== 1'((c == 3) ? 1 : 0) || bus.in_ready[1] !== (c == 3) ||
          bus.out_sop !== (c == 0 || c == 3) || bus.out_eop !== (c >= 2)) begin
        n_fail++;
        $display("FAIL lock_hold cycle %0d got port=%0d rdy=%b sop=%b eop=%b",
                 c, bus.out_port, bus.in_ready, bus.out_sop, bus.out_eop);
      end
    end
    @(negedge clk);
    idle_all();
  endtask

  // Port 0 bubbles 2 cycles mid-burst; port 1 must not be granted.
  task automatic test_bubble();
    int b;
    apply_reset();
    b = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      drive_port(1, 1'b1, 0, c);
      if (c == 2 || c == 3 || c == 6) drive_port(0, 1'b0, 0, 0);
      else drive_port(0, 1'b1, (c == 0) ? 3 : 0, b);
      #1;
      n_checks++;
      if (c == 2 || c == 3) begin
        if (bus.out_valid !== 1'b0 || bus.in_ready[1] !== 1'b0 || dbg_state !== ARB_BURST) begin
          n_fail++;
          $display("FAIL bubble_gap cycle %0d got v=%b rdy=%b state=%0d exp v=0 rdy1=0 state=1",
                   c, bus.out_valid, bus.in_ready, dbg_state);
        end
      end else if (c == 6) begin
        if (bus.out_valid !== 1'b1 || bus.out_port !== 1'b1 || bus.out_sop !== 1'b1) begin
          n_fail++;
          $display("FAIL bubble_next got v=%b port=%0d sop=%b exp v=1 port=1 sop=1",
                   bus.out_valid, bus.out_port, bus.out_sop);
        end
      end else begin
        if (bus.out_valid !== 1'b1 || bus.out_port !== 1'b0 || bus.out_eop !== (c == 5) ||
            bus.out_data !== mk(0, b)) begin
          n_fail++;
          $display("FAIL bubble_beat cycle %0d got v=%b port=%0d eop=%b exp v=1 port=0 eop=%b",
                   c, bus.out_valid, bus.out_port, bus.out_eop, (c == 5));
        end
        b++;
      end
    end
    @(negedge clk);
    idle_all();
  endtask

  // out_ready low holds the SOP; nothing is accepted.
  task automatic test_backpressure();
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.out_ready = (c >= 3);
      drive_port(0, 1'b1, (c <= 3) ? 1 : 0, (c <= 3) ? 0 : 1);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== ((c >= 3) ? 2'b01 : 2'b00) ||
          bus.out_sop !== (c <= 3) || bus.out_eop !== (c == 4)) begin
        n_fail++;
        $display("FAIL backpressure cycle %0d got v=%b rdy=%b sop=%b eop=%b",
                 c, bus.out_valid, bus.in_ready, bus.out_sop, bus.out_eop);
      end
    end
    @(negedge clk);
    idle_all();
    bus.out_ready = 1'b1;
  endtask

  // burstcount 255: exactly 256 beats, EOP only on the last.
  task automatic test_max_burst();
    apply_reset();
    for (int b = 0; b <= 256; b++) begin
      @(negedge clk);
      drive_port(0, 1'b1, (b == 0) ? 255 : 0, b);
      drive_port(1, 1'b1, 0, b);
      #1;
      n_checks++;
      if (b < 256) begin
        if (bus.out_port !== 1'b0 || bus.out_sop !== (b == 0) || bus.out_eop !== (b == 255)) begin
          n_fail++;
          $display("FAIL max_burst beat %0d got port=%0d sop=%b eop=%b exp port=0 sop=%b eop=%b",
                   b, bus.out_port, bus.out_sop, bus.out_eop, (b == 0), (b == 255));
        end
      end else begin
        if (bus.out_port !== 1'b1 || bus.out_sop !== 1'b1) begin
          n_fail++;
          $display("FAIL max_burst_after got port=%0d sop=%b exp port=1 sop=1", bus.out_port, bus.out_sop);
        end
      end
    end
    @(negedge clk);
    idle_all();
  endtask

  // Reset after beat 1 of a 4-beat burst drops the lock.
  task automatic test_reset_mid_burst();
    apply_reset();
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      drive_port(0, 1'b1, (b == 0) ? 3 : 0, b);
      drive_port(1, 1'b1, 0, b);
      #1;
      n_checks++;
      if (bus.out_port !== 1'b0 || bus.out_sop !== (b == 0)) begin
        n_fail++;
        $display("FAIL rst_mid_beat %0d got port=%0d sop=%b exp port=0 sop=%b", b, bus.out_port, bus.out_sop, (b == 0));
      end
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 2'b00 || dbg_state !== ARB_IDLE) begin
      n_fail++;
      $display("FAIL rst_mid_assert got v=%b rdy=%b state=%0d exp v=0 rdy=00 state=0",
               bus.out_valid, bus.in_ready, dbg_state);
    end
    @(negedge clk);
    reset_n = 1'b1;
    drive_port(0, 1'b1, 3, 9);
    drive_port(1, 1'b1, 0, 9);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sop !== 1'b1 || bus.out_port !== 1'b0 || bus.out_eop !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_release got v=%b sop=%b port=%0d eop=%b exp v=1 sop=1 port=0 eop=0",
               bus.out_valid, bus.out_sop, bus.out_port, bus.out_eop);
    end
    @(negedge clk);
    idle_all();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bus.out_ready = 1'b1;
    idle_all();
    test_reset();
    test_single_burst();
    test_alternate();
    test_lock_hold();
    test_bubble();
    test_backpressure();
    test_max_burst();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ofs_plat_prim_burstcount0_write_arbiter.md
# ofs_plat_prim_burstcount0_write_arbiter

Round-robin arbiter sharing one burst-structured write channel (data flits grouped into packets, AXI-style burst count where 0 means one beat) among NUM_PORTS requesters. Arbitration happens only at packet boundaries: once a port wins at SOP, the grant stays locked until that port's EOP beat is accepted. The block sits between AFU-side write sources and a single downstream memory or host write channel, and emits SOP, EOP and source-port tags for downstream consumers.

## Interface
- NUM_PORTS, 2: number of requesters, 2..16.
- BURST_CNT_WIDTH, 8: burst count width, origin 0 (0 = 1 beat).
- DATA_WIDTH, 512: payload width per flit, including any user/mask bits the caller packs.
- clk  in  1  single clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset (asserted asynchronously, released synchronously by the caller).
- in_valid  in  NUM_PORTS  per-port flit valid.
- in_ready  out  NUM_PORTS  per-port flit accept.
- in_burstcount  in  NUM_PORTS x BURST_CNT_WIDTH  per-port burst length; sampled only on that port's SOP flit.
- in_data  in  NUM_PORTS x DATA_WIDTH  per-port payload.
- out_valid  out  1  downstream flit valid.
- out_ready  in  1  downstream accept.
- out_burstcount  out  BURST_CNT_WIDTH  granted port's in_burstcount, passed through on every beat.
- out_data  out  DATA_WIDTH  granted port's payload.
- out_sop  out  1  current out flit is first of packet.
- out_eop  out  1  current out flit is last of packet.
- out_port  out  clog2(NUM_PORTS), min 1  index of granted port.

## Operation
- State: locked (1b), lock_port, last_grant (round-robin pointer), flits_rem (BURST_CNT_WIDTH).
- Unlocked (IDLE/SOP state):
  - Winner = first port with in_valid set, searching round-robin from last_grant+1 mod NUM_PORTS.
  - out_sop=1.
  - out_eop = (winner in_burstcount == 0).
- Locked (BURST state):
  - Winner = lock_port regardless of other valids.
  - out_sop=0.
  - out_eop = (flits_rem == 0).
- Forwarding: out_valid = winner exists (unlocked) or in_valid[lock_port] (locked). out_data, out_burstcount and out_port are muxed from the winner.
- Ready: in_ready[i] = out_ready && (i == winner). All other ports see 0. in_ready never depends on in_valid of the same port except through winner selection.
- Beat accepted (out_valid && out_ready):
  - If SOP and burstcount == 0: stay unlocked, last_grant <= winner.
  - If SOP and burstcount > 0: locked <= 1, lock_port <= winner, flits_rem <= burstcount-1, last_grant <= winner.
  - If locked: flits_rem <= flits_rem-1. If flits_rem == 0 (EOP), locked <= 0.
- Arithmetic: flits_rem is modulo 2^BURST_CNT_WIDTH. Maximum burst = 2^BURST_CNT_WIDTH beats. Burstcount is all-ones for maximum.
- Locked with in_valid[lock_port] low: out_valid=0 and the lock is held. Bubbles within a packet never release the grant.
- Burstcount changes on non-SOP beats are ignored for length tracking.

## Timing
- Zero-cycle latency: all out_* are combinational from inputs plus registered state. No buffering.
- Arbitration decision and grant update take effect the cycle after the accepted SOP beat.
- Single-beat packets from different ports may issue on consecutive cycles.
- Reset values (while reset_n low):
  - locked=0, lock_port=0, flits_rem=0.
  - last_grant=NUM_PORTS-1, so port 0 has first priority.
  - in_ready all 0, out_valid=0, out_sop=1, out_eop=0, out_port=0. The forwarding and eop equations are gated by reset.
- Reset mid-burst: the lock is dropped immediately. The next flit after release is treated as SOP. Callers must reset sources together.
- out_ready low holds all state. The winner selection is stable while unlocked only if in_valid inputs are stable (AXI rule: sources must not drop valid).

## Structure
- Shared package ofs_plat_prim_arb_pkg: no new types required. Port index width is computed locally as $clog2 with minimum 1.
- Sub-module ofs_plat_prim_rr_select #(NUM_PORTS):
  - Inputs: request vector, last_grant.
  - Outputs: winner_valid, winner_idx.
  - Purely combinational.
- Top holds the lock/counter state and the muxes.

## Test plan
- Single port, burstcount=3, out_ready=1: 4 beats out. out_sop only on beat 0, out_eop only on beat 3, then unlocked.
- Ports 0 and 1 both valid with burstcount=0, repeated: grants alternate 0,1,0,1 each cycle, out_port matches.
- Port 0 burstcount=2 with port 1 valid throughout: 3 port-0 beats are contiguous, then port 1 wins. Port 1 in_ready stays 0 during port 0's burst.
- Port 0 mid-burst drops in_valid for 2 cycles while port 1 is valid: out_valid=0 during the gap, no grant to port 1, port 0 then resumes and completes.
- burstcount=255 (BURST_CNT_WIDTH=8): exactly 256 beats, out_eop on the last beat, no early wrap.
- reset_n asserted after beat 1 of a 4-beat burst, then released: the next accepted flit has out_sop=1, and port 0 has priority.
